// File: rtl/btn_deb_pkg.sv
// Shared defaults, constant clog2 helper and per-channel state type for btn_debounce_nch.
package btn_deb_pkg;

  localparam int DEF_N_CH       = 4;
  localparam int DEF_DEPTH      = 3;
  localparam int DEF_LONG_CNT   = 200;
  localparam int DEF_REPEAT_CNT = 40;

  function automatic int clog2(input int value);
    int width;
    int rem;
    width = 0;
    rem   = value - 1;
    while (rem > 0) begin
      width = width + 1;
      rem   = rem >> 1;
    end
    return width;
  endfunction

  typedef enum logic [1:0] {
    REL  = 2'd0,
    PRS  = 2'd1,
    LONG = 2'd2
  } chan_state_e;

endpackage

// File: rtl/btn_deb_chan.sv
// One button channel: 2-flop sync, DEPTH-sample shift register, REL/PRS/LONG state, hold counter.
// Auto-repeat pulses are generated only when BTN_AUTO_REPEAT_EN is defined.
module btn_deb_chan
  import btn_deb_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int LONG_CNT   = DEF_LONG_CNT,
  parameter int REPEAT_CNT = DEF_REPEAT_CNT
) (
  input  logic clk_169344,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_deb,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long,
  output logic btn_repeat
);

  localparam int              CNT_W   = clog2(LONG_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LONG_CNT);

  logic [1:0]       sync_q, sync_d;
  logic [DEPTH-1:0] shift_q, shift_d;
  chan_state_e      state_q, state_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it unassigned and no latch is inferred.
    sync_d    = {sync_q[0], btn_raw};
    shift_d   = {shift_q[DEPTH-2:0], sync_q[1]};
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    cnt_d     = cnt_q;

    unique case (state_q)
      REL: if (&shift_q) begin
        state_d = PRS;
        press_d = 1'b1;
      end
      PRS, LONG: if (~|shift_q) begin
        state_d   = REL;
        release_d = 1'b1;
      end
      default: state_d = REL;
    endcase

    // The count starts on the edge after the debounced rise, so LONG lands exactly LONG_CNT edges later.
    if (state_d == REL) begin
      cnt_d = '0;
    end else if (state_q != REL && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (state_d == PRS && cnt_d == CNT_MAX) state_d = LONG;
  end

  // NOTE: every flop, including the synchroniser, is cleared by the async reset so outputs read released at once.
  always_ff @(posedge clk_169344 or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      shift_q   <= '0;
      state_q   <= REL;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values together.
      sync_q    <= sync_d;
      shift_q   <= shift_d;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
      cnt_q     <= cnt_d;
    end
  end

  assign btn_deb     = (state_q != REL);
  assign btn_long    = (state_q == LONG);
  assign btn_press   = press_q;
  assign btn_release = release_q;

`ifdef BTN_AUTO_REPEAT_EN
  localparam int               RPT_W    = clog2(REPEAT_CNT);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CNT - 1);

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_q, rpt_d;

  // First pulse on the LONG entry edge, then one every REPEAT_CNT edges while LONG holds.
  always_comb begin
    rpt_cnt_d = '0;
    rpt_d     = 1'b0;
    if (state_d == LONG) begin
      if (state_q != LONG || rpt_cnt_q == RPT_LAST) begin
        rpt_d = 1'b1;
      end else begin
        rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_169344 or posedge rst) begin
    if (rst) begin
      rpt_cnt_q <= '0;
      rpt_q     <= 1'b0;
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
      rpt_q     <= rpt_d;
    end
  end

  assign btn_repeat = rpt_q;
`else
  assign btn_repeat = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce_nch.sv
// N-channel button conditioner: polarity normalisation plus N_CH independent btn_deb_chan instances.
// Optional auto-repeat outputs are enabled by defining BTN_AUTO_REPEAT_EN.
module btn_debounce_nch
  import btn_deb_pkg::*;
#(
  parameter int N_CH       = DEF_N_CH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ACTIVE_LOW = 0,
  parameter int LONG_CNT   = DEF_LONG_CNT,
  parameter int REPEAT_CNT = DEF_REPEAT_CNT
) (
  input  logic            clk_169344,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_deb,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic [N_CH-1:0] btn_long,
  output logic [N_CH-1:0] btn_repeat
);

  logic [N_CH-1:0] btn_norm;

  // Internally a button is always "pressed = 1" from the first synchroniser stage on.
  assign btn_norm = (ACTIVE_LOW != 0) ? ~btn_in : btn_in;

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    btn_deb_chan #(
      .DEPTH      (DEPTH),
      .LONG_CNT   (LONG_CNT),
      .REPEAT_CNT (REPEAT_CNT)
    ) u_chan (
      .clk_169344  (clk_169344),
      .rst         (rst),
      .btn_raw     (btn_norm[i]),
      .btn_deb     (btn_deb[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i]),
      .btn_long    (btn_long[i]),
      .btn_repeat  (btn_repeat[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce_nch.sv
// Scoreboard bench for btn_debounce_nch: stimulus queues expected output changes, a monitor compares them.
module tb_btn_debounce_nch;

  logic       clk_169344 = 1'b0;
  logic       rst        = 1'b1;
  logic [3:0] btn_in     = 4'b0000;
  logic [3:0] btn_in_al  = 4'b1111;
  logic [3:0] deb, prs, rel, lng, rpt;
  logic [3:0] deb_al, prs_al, rel_al, lng_al, rpt_al;

  btn_debounce_nch dut (
    .clk_169344  (clk_169344),
    .rst         (rst),
    .btn_in      (btn_in),
    .btn_deb     (deb),
    .btn_press   (prs),
    .btn_release (rel),
    .btn_long    (lng),
    .btn_repeat  (rpt)
  );

  btn_debounce_nch #(.ACTIVE_LOW(1)) dut_al (
    .clk_169344  (clk_169344),
    .rst         (rst),
    .btn_in      (btn_in_al),
    .btn_deb     (deb_al),
    .btn_press   (prs_al),
    .btn_release (rel_al),
    .btn_long    (lng_al),
    .btn_repeat  (rpt_al)
  );

  always #5 clk_169344 = ~clk_169344;

  int cyc = 0;
  always @(posedge clk_169344) cyc <= cyc + 1;

  // Observed signal ids; ids 5..9 are the same buses of the active-low instance.
  localparam int S_DEB = 0, S_PRS = 1, S_REL = 2, S_LNG = 3, S_RPT = 4, AL = 5;

  typedef struct {
    int         cy;
    int         sig;
    logic [3:0] val;
  } ev_t;

  ev_t        exp_q[$];
  int         total = 0;
  int         bad   = 0;
  logic [3:0] prev[10];
  bit         mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  function automatic logic [3:0] sample(input int s);
    case (s)
      0:       return deb;
      1:       return prs;
      2:       return rel;
      3:       return lng;
      4:       return rpt;
      5:       return deb_al;
      6:       return prs_al;
      7:       return rel_al;
      8:       return lng_al;
      9:       return rpt_al;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic ev(input int cy, input int sig, input logic [3:0] v);
    exp_q.push_back(ev_t'{cy, sig, v});
  endtask

  task automatic exp_press(input int c, input int off, input logic [3:0] mask, input logic [3:0] deb_after);
    ev(c, off + S_DEB, deb_after);
    ev(c, off + S_PRS, mask);
    ev(c + 1, off + S_PRS, 4'b0000);
  endtask

  task automatic exp_release(input int c, input int off, input logic [3:0] mask,
                             input logic [3:0] deb_after, input bit was_long);
    ev(c, off + S_DEB, deb_after);
    ev(c, off + S_REL, mask);
    if (was_long) ev(c, off + S_LNG, 4'b0000);
    ev(c + 1, off + S_REL, 4'b0000);
  endtask

  // Monitor: every change on an output bus is one DUT event, matched in (cycle, signal) order.
  always @(negedge clk_169344) begin
    if (mon_en) begin
      for (int s = 0; s < 10; s++) begin
        logic [3:0] cur;
        ev_t        e;
        cur = sample(s);
        if (cur !== prev[s]) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: cycle %0d sig %0d got %b, nothing expected", cyc, s, cur);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("event_cyc%0d_sig%0d", e.cy, e.sig),
                  {32'(cyc), 28'(s), cur}, {32'(e.cy), 28'(e.sig), e.val});
          end
          prev[s] = cur;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk_169344);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk_169344);
  endtask

  task automatic drain();
    int budget;
    ev_t e;
    budget = 0;
    while (exp_q.size() != 0 && budget < 700) begin
      @(negedge clk_169344);
      budget++;
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total++;
      bad++;
      $display("FAIL missing_event: cycle %0d sig %0d want %b, never seen", e.cy, e.sig, e.val);
    end
    step(3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, d, m, r;

    step(3);
    check("reset_outputs", {24'd0, deb, prs, rel, lng, rpt, deb_al, prs_al, rel_al, lng_al, rpt_al}, 64'd0);
    for (int s = 0; s < 10; s++) prev[s] = sample(s);
    mon_en = 1'b1;
    rst    = 1'b0;
    step(5);

    // Clean press and release on ch0.
    c = cyc;
    btn_in[0] = 1'b1;
    exp_press(c + 6, 0, 4'b0001, 4'b0001);
    step(15);
    c = cyc;
    btn_in[0] = 1'b0;
    exp_release(c + 6, 0, 4'b0001, 4'b0000, 1'b0);
    drain();

    // Bounce on ch1 press: 1,0,1,1,0 then held; only the final 0->1 counts.
    c = cyc;
    exp_press(c + 11, 0, 4'b0010, 4'b0010);
    btn_in[1] = 1'b1; step(1);
    btn_in[1] = 1'b0; step(1);
    btn_in[1] = 1'b1; step(1);
    btn_in[1] = 1'b1; step(1);
    btn_in[1] = 1'b0; step(1);
    btn_in[1] = 1'b1;
    step(15);
    // Mirrored bounce on release: 0,1,0,0,1 then held low.
    c = cyc;
    exp_release(c + 11, 0, 4'b0010, 4'b0000, 1'b0);
    btn_in[1] = 1'b0; step(1);
    btn_in[1] = 1'b1; step(1);
    btn_in[1] = 1'b0; step(1);
    btn_in[1] = 1'b0; step(1);
    btn_in[1] = 1'b1; step(1);
    btn_in[1] = 1'b0;
    drain();

    // Active-low instance: all four channels pressed and released together.
    c = cyc;
    btn_in_al = 4'b0000;
    exp_press(c + 6, AL, 4'b1111, 4'b1111);
    step(10);
    c = cyc;
    btn_in_al = 4'b1111;
    exp_release(c + 6, AL, 4'b1111, 4'b0000, 1'b0);
    drain();

    // Long press on ch2 for 250 cycles.
    c = cyc;
    d = c + 6;
    btn_in[2] = 1'b1;
    exp_press(d, 0, 4'b0100, 4'b0100);
    ev(d + 200, S_LNG, 4'b0100);
`ifdef BTN_AUTO_REPEAT_EN
    ev(d + 200, S_RPT, 4'b0100);
    ev(d + 201, S_RPT, 4'b0000);
    ev(d + 240, S_RPT, 4'b0100);
    ev(d + 241, S_RPT, 4'b0000);
`endif
    wait_until(c + 250);
    btn_in[2] = 1'b0;
    exp_release(c + 256, 0, 4'b0100, 4'b0000, 1'b1);
    drain();

    // Long press on ch3 for 330 cycles (repeat pulses at +200, +240, +280, +320 when enabled).
    c = cyc;
    d = c + 6;
    btn_in[3] = 1'b1;
    exp_press(d, 0, 4'b1000, 4'b1000);
    ev(d + 200, S_LNG, 4'b1000);
`ifdef BTN_AUTO_REPEAT_EN
    for (int k = 0; k < 4; k++) begin
      ev(d + 200 + 40 * k, S_RPT, 4'b1000);
      ev(d + 201 + 40 * k, S_RPT, 4'b0000);
    end
`endif
    wait_until(c + 330);
    btn_in[3] = 1'b0;
    exp_release(c + 336, 0, 4'b1000, 4'b0000, 1'b1);
    drain();

    // Reset 100 cycles into a ch0 hold, then the still-held button is a fresh press.
    c = cyc;
    d = c + 6;
    btn_in[0] = 1'b1;
    exp_press(d, 0, 4'b0001, 4'b0001);
    wait_until(d + 99);
    @(posedge clk_169344);
    #2;
    ev(d + 100, S_DEB, 4'b0000);
    rst = 1'b1;
    #1;
    check("async_reset_drop", {48'd0, deb, prs, rel, lng}, 64'd0);
    wait_until(d + 103);
    rst = 1'b0;
    m = cyc;
    exp_press(m + 6, 0, 4'b0001, 4'b0001);
    wait_until(m + 20);
    btn_in[0] = 1'b0;
    r = cyc;
    exp_release(r + 6, 0, 4'b0001, 4'b0000, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btn_debounce_nch.md
Name: btn_debounce_nch

Overview:
Parametrised N-channel button conditioner. It debounces each button symmetrically on both press and release, and produces press/release strobes and a long-press flag per channel. It runs entirely on the divided sampling clock clk_169344, between raw board buttons and the control FSMs. Channels are independent and identical.

Parameters:
N_CH, 4, number of button channels.
DEPTH, 3, consecutive equal samples required to change debounced state (legal range 2..16).
ACTIVE_LOW, 0, 1 = raw button reads 0 when pressed; inputs are normalised to logical "pressed = 1" before synchronisation.
LONG_CNT, 200, clk_169344 cycles of continuous debounced press before btn_long asserts (legal range ≥ 2).
REPEAT_CNT, 40, auto-repeat period in clk_169344 cycles (legal range ≥ 2; used only with the optional feature).

Ports:
clk_169344  in  1  sampling clock; all state updates on its rising edge.
rst  in  1  asynchronous, active-high reset.
btn_in  in  N_CH  raw, asynchronous button levels.
btn_deb  out  N_CH  debounced level, 1 = pressed.
btn_press  out  N_CH  one-cycle pulse on the debounced rising edge.
btn_release  out  N_CH  one-cycle pulse on the debounced falling edge.
btn_long  out  N_CH  level; high while pressed continuously for ≥ LONG_CNT cycles.
btn_repeat  out  N_CH  one-cycle auto-repeat pulses (optional feature; 0 when compiled out).

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk_169344. While rst = 1, all synchronisers, shift registers, counters and outputs are 0 (logical released), regardless of ACTIVE_LOW.
- Per-channel pipeline: normalise polarity -> 2-flop synchroniser -> DEPTH-bit shift register -> state register.
- State update at each edge:
  - Shift register all ones and btn_deb = 0: btn_deb <= 1, btn_press <= 1.
  - Shift register all zeros and btn_deb = 1: btn_deb <= 0, btn_release <= 1.
  - Otherwise btn_deb holds, and btn_press and btn_release return to 0.
- Latency: a clean level change first sampled at edge k appears on btn_deb and the strobe at edge k+DEPTH+2. For DEPTH = 3 this is 5 edges after the first sampling edge, 6 edges counting that edge.
- Glitch rejection: any pulse or gap shorter than DEPTH consecutive samples leaves btn_deb unchanged and produces no strobe, in both directions.
- Press and release are mutually exclusive per channel per cycle. Strobes are never longer than 1 cycle.
- Hold counter (per channel):
  - Width is clog2(LONG_CNT+1).
  - Cleared while btn_deb = 0, including on the edge where btn_deb falls.
  - Increments while btn_deb = 1 and saturates at LONG_CNT; it does not wrap.
  - btn_long = (cnt == LONG_CNT), registered. It rises exactly LONG_CNT edges after btn_deb rises and falls on the same edge as btn_deb.
- Channels share nothing. Simultaneous events on different channels are handled independently in the same cycle.
- Reset mid-operation: all state clears immediately. After rst deasserts, a button still held is treated as a new press: btn_press fires DEPTH+2 edges later, and the long count restarts.

Optional Feature:
Macro BTN_AUTO_REPEAT_EN.
- Defined: a per-channel repeat counter of width clog2(REPEAT_CNT) is active.
  - btn_repeat pulses for 1 cycle on the edge btn_long first rises.
  - It then pulses every REPEAT_CNT edges while btn_long stays 1.
  - The counter clears when btn_long falls or on rst.
- Undefined: btn_repeat is driven constant 0, the repeat counter logic is absent, and the port list is unchanged.

Decomposition:
- Package btn_deb_pkg holds:
  - default constants (N_CH, DEPTH, LONG_CNT, REPEAT_CNT);
  - a constant clog2 function;
  - the per-channel state enum {REL, PRS, LONG}.
- Sub-module btn_deb_chan implements one channel: sync, shift register, state, hold and repeat counters. The top instantiates it N_CH times in a generate loop and does the polarity normalisation.

Test Plan:
- Clean press: defaults, hold btn_in[0] = 1 from edge 10 -> btn_deb[0] = 1 and 1-cycle btn_press[0] at edge 15; no activity on other channels.
- Bounce: btn_in[1] toggles 1,0,1,1,0 (changing every edge), then is held at 1 -> no press during the bounce; single btn_press[1] DEPTH+2 edges after the last 0 -> 1 transition. Mirror the test for release.
- Long press: hold ch2 for 250 cycles -> btn_long[2] rises 200 edges after btn_deb[2] rises. On release, btn_long[2] and btn_deb[2] fall together, with one btn_release[2] pulse.
- Simultaneous channels with ACTIVE_LOW = 1: drive btn_in = 4'b0000 at one edge -> all four btn_press bits pulse on the same edge; btn_deb = 4'b1111.
- Reset mid-press: assert rst asynchronously at cycle 100 of a ch0 hold (btn_long = 0) -> all outputs drop immediately. After release with the button still held, btn_press[0] fires again DEPTH+2 edges later.
- BTN_AUTO_REPEAT_EN defined: hold ch3 for 330 cycles -> btn_repeat[3] pulses at cycles 200, 240, 280 and 320 after the btn_deb rise. With the macro undefined, btn_repeat stays 0 throughout.
